// File: rtl/clock_set_pkg.sv
// Shared types and constants for the time-entry controller: FSM states,
// field-select codes, BCD field limits and snapshot clean-up.
package clock_set_pkg;

  typedef logic [7:0] bcd8_t;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HH,
    EDIT_MM,
    EDIT_SS,
    COMMIT
  } state_t;

  localparam logic [1:0] FS_NONE = 2'd0;
  localparam logic [1:0] FS_HH   = 2'd1;
  localparam logic [1:0] FS_MM   = 2'd2;
  localparam logic [1:0] FS_SS   = 2'd3;

  localparam bcd8_t HH_MAX = 8'h23;
  localparam bcd8_t MS_MAX = 8'h59;

  // Any digit outside its legal range for this field becomes 0.
  function automatic bcd8_t bcd_sanitize(input bcd8_t val, input bcd8_t max);
    bcd8_t res;
    res = val;
    if (val[7:4] > max[7:4]) res[7:4] = 4'd0;
    if (val[3:0] > 4'd9 || (val[7:4] == max[7:4] && val[3:0] > max[3:0]))
      res[3:0] = 4'd0;
    return res;
  endfunction

endpackage

// File: rtl/bcd_field_adj.sv
// Combinational one-step BCD field adjuster with wrap at 00 and at max.
// Up and down together leave the value unchanged.
module bcd_field_adj
  import clock_set_pkg::*;
(
  input  bcd8_t val,
  input  bcd8_t max,
  input  logic  up,
  input  logic  down,
  output bcd8_t next
);

  bcd8_t inc;
  bcd8_t dec;

  always_comb begin
    if (val == max)              inc = 8'h00;
    else if (val[3:0] == 4'd9)   inc = {val[7:4] + 4'd1, 4'd0};
    else                         inc = {val[7:4], val[3:0] + 4'd1};

    if (val == 8'h00)            dec = max;
    else if (val[3:0] == 4'd0)   dec = {val[7:4] - 4'd1, 4'd9};
    else                         dec = {val[7:4], val[3:0] - 4'd1};

    case ({up, down})
      2'b10:   next = inc;
      2'b01:   next = dec;
      default: next = val;
    endcase
  end

endmodule

// File: rtl/clock_time_setter.sv
// Time-entry controller feeding the load side of the BCD clock.
// Define CLOCK_SET_DOWN_EN to enable btn_down; otherwise fields only step up.
module clock_time_setter
  import clock_set_pkg::*;
#(
  parameter int SET_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES   = 30
) (
  input  logic        clk,
  input  logic        reset_time_n,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_cancel,
  input  logic [23:0] time_now,
  output logic [23:0] time_in,
  output logic        set_time,
  output logic        editing,
  output logic [1:0]  field_sel
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam int PC_W = $clog2(SET_PULSE_CYCLES + 1);

  state_t            state;
  logic [23:0]       edit_reg;
  logic [TO_W-1:0]   to_cnt;
  logic [PC_W-1:0]   pulse_cnt;
  logic [3:0]        btn_cur;
  logic [3:0]        btn_prev;
  logic [3:0]        btn_edge;
  logic              down_in;

`ifdef CLOCK_SET_DOWN_EN
  assign down_in = btn_down;
`else
  logic unused_down;
  assign unused_down = btn_down;
  assign down_in     = 1'b0;
`endif

  // Edge bit order: {cancel, mode, up, down}
  assign btn_edge = btn_cur & ~btn_prev;

  logic cancel_edge, mode_edge, up_edge, down_edge;
  assign cancel_edge = btn_edge[3];
  assign mode_edge   = btn_edge[2];
  assign up_edge     = btn_edge[1];
  assign down_edge   = btn_edge[0];

  bcd8_t adj_val;
  bcd8_t adj_max;
  bcd8_t adj_next;

  always_comb begin
    adj_val = edit_reg[23:16];
    adj_max = HH_MAX;
    case (field_sel)
      FS_MM: begin adj_val = edit_reg[15:8]; adj_max = MS_MAX; end
      FS_SS: begin adj_val = edit_reg[7:0];  adj_max = MS_MAX; end
      default: ;
    endcase
  end

  bcd_field_adj u_adj (
    .val  (adj_val),
    .max  (adj_max),
    .up   (up_edge),
    .down (down_edge),
    .next (adj_next)
  );

  always_ff @(posedge clk or negedge reset_time_n) begin
    if (!reset_time_n) begin
      state     <= IDLE;
      btn_cur   <= '0;
      btn_prev  <= '0;
      edit_reg  <= '0;
      to_cnt    <= '0;
      pulse_cnt <= '0;
      time_in   <= '0;
      set_time  <= 1'b0;
      editing   <= 1'b0;
      field_sel <= FS_NONE;
    end else begin
      btn_prev <= btn_cur;
      btn_cur  <= {btn_cancel, btn_mode, btn_up, down_in};
      case (state)
        IDLE: begin
          if (mode_edge) begin
            edit_reg  <= {bcd_sanitize(time_now[23:16], HH_MAX),
                          bcd_sanitize(time_now[15:8],  MS_MAX),
                          bcd_sanitize(time_now[7:0],   MS_MAX)};
            state     <= EDIT_HH;
            editing   <= 1'b1;
            field_sel <= FS_HH;
            to_cnt    <= '0;
          end
        end
        EDIT_HH, EDIT_MM, EDIT_SS: begin
          to_cnt <= to_cnt + 1'b1;
          if (cancel_edge) begin
            state     <= IDLE;
            editing   <= 1'b0;
            field_sel <= FS_NONE;
          end else if (mode_edge) begin
            to_cnt <= '0;
            if (state == EDIT_HH) begin
              state     <= EDIT_MM;
              field_sel <= FS_MM;
            end else if (state == EDIT_MM) begin
              state     <= EDIT_SS;
              field_sel <= FS_SS;
            end else begin
              // Load value is frozen here and held until the next commit
              state     <= COMMIT;
              editing   <= 1'b0;
              field_sel <= FS_NONE;
              time_in   <= edit_reg;
              set_time  <= 1'b1;
              pulse_cnt <= '0;
            end
          end else if (up_edge || down_edge) begin
            to_cnt <= '0;
            case (field_sel)
              FS_HH:   edit_reg[23:16] <= adj_next;
              FS_MM:   edit_reg[15:8]  <= adj_next;
              default: edit_reg[7:0]   <= adj_next;
            endcase
          end else if (TIMEOUT_CYCLES != 0 && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            editing   <= 1'b0;
            field_sel <= FS_NONE;
          end
        end
        COMMIT: begin
          if (pulse_cnt == PC_W'(SET_PULSE_CYCLES - 1)) begin
            set_time <= 1'b0;
            state    <= IDLE;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench for clock_time_setter with an integer-arithmetic reference
// model checked every cycle, plus literal expectations per scenario.
module tb_clock_time_setter;

  logic        clk          = 1'b0;
  logic        reset_time_n = 1'b0;
  logic        btn_mode     = 1'b0;
  logic        btn_up       = 1'b0;
  logic        btn_down     = 1'b0;
  logic        btn_cancel   = 1'b0;
  logic [23:0] time_now     = 24'h000000;
  logic [23:0] time_in;
  logic        set_time;
  logic        editing;
  logic [1:0]  field_sel;

  always #5 clk = ~clk;

  clock_time_setter #(.SET_PULSE_CYCLES(2), .TIMEOUT_CYCLES(30)) dut (
    .clk          (clk),
    .reset_time_n (reset_time_n),
    .btn_mode     (btn_mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_cancel   (btn_cancel),
    .time_now     (time_now),
    .time_in      (time_in),
    .set_time     (set_time),
    .editing      (editing),
    .field_sel    (field_sel)
  );

`ifdef CLOCK_SET_DOWN_EN
  localparam bit          DOWN_EN = 1'b1;
  localparam logic [23:0] EXP_FULL  = 24'h143357;
  localparam logic [23:0] EXP_WRAP  = 24'h000058;
  localparam logic [23:0] EXP_CARRY = 24'h105900;
  localparam logic [23:0] EXP_SIM   = 24'h050504;
`else
  localparam bit          DOWN_EN = 1'b0;
  localparam logic [23:0] EXP_FULL  = 24'h143457;
  localparam logic [23:0] EXP_WRAP  = 24'h000059;
  localparam logic [23:0] EXP_CARRY = 24'h100000;
  localparam logic [23:0] EXP_SIM   = 24'h050605;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int pulse_cycles = 0;

  // Reference model: phase 0 idle, 1..3 editing HH/MM/SS, 4 load pulse
  int          m_phase = 0, m_hh = 0, m_mm = 0, m_ss = 0, m_idle = 0, m_pcnt = 0;
  logic [23:0] m_tin = 24'h0;
  logic        m_set = 1'b0;
  logic [3:0]  h1 = 4'h0, h2 = 4'h0, ev;

  function automatic logic [7:0] int2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int snap(input logic [7:0] b, input int maxv);
    int t, u, nt, nu;
    t  = int'(b[7:4]);
    u  = int'(b[3:0]);
    nt = (t > maxv / 10) ? 0 : t;
    nu = (u > 9 || (t == maxv / 10 && u > maxv % 10)) ? 0 : u;
    return nt * 10 + nu;
  endfunction

  function automatic int step(input int v, input int range, input bit up, input bit dn);
    if (up && !dn) return (v + 1) % range;
    if (dn && !up) return (v + range - 1) % range;
    return v;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_time_n);
    if (!reset_time_n) begin
      m_phase = 0; m_idle = 0; m_pcnt = 0; m_tin = 24'h0; m_set = 1'b0;
      h1 = 4'h0; h2 = 4'h0;
    end else begin
      ev = h1 & ~h2;
      h2 = h1;
      h1 = {btn_cancel, btn_mode, btn_up, btn_down & DOWN_EN};
      case (m_phase)
        0: if (ev[2]) begin
          m_hh = snap(time_now[23:16], 23);
          m_mm = snap(time_now[15:8], 59);
          m_ss = snap(time_now[7:0], 59);
          m_phase = 1; m_idle = 0;
        end
        1, 2, 3: begin
          if (ev[3]) m_phase = 0;
          else if (ev[2]) begin
            m_phase++; m_idle = 0;
            if (m_phase == 4) begin
              m_tin = {int2bcd(m_hh), int2bcd(m_mm), int2bcd(m_ss)};
              m_set = 1'b1; m_pcnt = 0;
            end
          end else if (ev[1] || ev[0]) begin
            m_idle = 0;
            if (m_phase == 1)      m_hh = step(m_hh, 24, ev[1], ev[0]);
            else if (m_phase == 2) m_mm = step(m_mm, 60, ev[1], ev[0]);
            else                   m_ss = step(m_ss, 60, ev[1], ev[0]);
          end else begin
            m_idle++;
            if (m_idle == 30) m_phase = 0;
          end
        end
        default: begin
          m_pcnt++;
          if (m_pcnt == 2) begin m_set = 1'b0; m_phase = 0; end
        end
      endcase
    end
  end

  logic       exp_edit;
  logic [1:0] exp_fsel;
  initial forever begin
    @(negedge clk);
    exp_edit = (m_phase >= 1 && m_phase <= 3);
    exp_fsel = exp_edit ? 2'(m_phase) : 2'd0;
    n_vec++;
    if (time_in !== m_tin || set_time !== m_set || editing !== exp_edit || field_sel !== exp_fsel) begin
      n_bad++;
      $display("FAIL cycle t=%0t: got time_in=%h set=%b edit=%b fsel=%0d, need %h %b %b %0d",
               $time, time_in, set_time, editing, field_sel, m_tin, m_set, exp_edit, exp_fsel);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (set_time) pulse_cycles++;
  endtask

  task automatic press(input bit m, input bit u, input bit d, input bit c);
    btn_mode = m; btn_up = u; btn_down = d; btn_cancel = c;
    tick();
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_cancel = 1'b0;
    tick();
  endtask

  task automatic mode_x(input int n);
    for (int i = 0; i < n; i++) press(1, 0, 0, 0);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((set_time || editing) && i < 40) begin tick(); i++; end
    if (set_time || editing) begin
      n_vec++; n_bad++;
      $display("FAIL wait_idle: still busy set=%b edit=%b, need 0 0", set_time, editing);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outputs", {4'h0, time_in, set_time, editing, field_sel}, 32'h0);
    reset_time_n = 1'b1;
    tick();

    // Full edit from 12:34:56
    pulse_cycles = 0;
    time_now = 24'h123456;
    press(1, 0, 0, 0);
    check("enter_hh", {30'h0, field_sel}, 32'd1);
    press(0, 1, 0, 0); press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    check("full_set_high", {31'h0, set_time}, 32'd1);
    wait_idle();
    check("full_time_in", {8'h0, time_in}, {8'h0, EXP_FULL});
    check("full_pulse_len", pulse_cycles, 32'd2);

    // Wrap on every field from 23:59:59
    time_now = 24'h235959;
    press(1, 0, 0, 0); press(0, 1, 0, 0);
    press(1, 0, 0, 0); press(0, 1, 0, 0);
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    wait_idle();
    check("wrap_time_in", {8'h0, time_in}, {8'h0, EXP_WRAP});

    // Digit carries: 09->10, MM 00 down
    time_now = 24'h090000;
    press(1, 0, 0, 0); press(0, 1, 0, 0);
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    mode_x(2);
    wait_idle();
    check("carry09_time_in", {8'h0, time_in}, {8'h0, EXP_CARRY});

    // 19->20 with btn_up held for ten cycles
    time_now = 24'h194510;
    press(1, 0, 0, 0);
    btn_up = 1'b1;
    repeat (10) tick();
    btn_up = 1'b0;
    tick();
    check("hold_still_hh", {30'h0, field_sel}, 32'd1);
    mode_x(3);
    wait_idle();
    check("hold_time_in", {8'h0, time_in}, 32'h00204510);

    // Cancel in MM: no load
    pulse_cycles = 0;
    time_now = 24'h111111;
    press(1, 0, 0, 0); press(0, 1, 0, 0); press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    check("cancel_idle", {31'h0, editing}, 32'd0);
    check("cancel_time_in", {8'h0, time_in}, 32'h00204510);

    // Timeout in SS
    mode_x(3);
    repeat (20) tick();
    check("timeout_not_yet", {30'h0, editing, field_sel[1]}, 32'h3);
    repeat (12) tick();
    check("timeout_idle", {31'h0, editing}, 32'd0);
    check("timeout_time_in", {8'h0, time_in}, 32'h00204510);
    check("cancel_no_pulse", pulse_cycles, 32'd0);

    // Buttons other than mode are ignored in idle
    press(0, 1, 0, 0); press(0, 0, 1, 0); press(0, 0, 0, 1);
    check("idle_ignore", {31'h0, editing}, 32'd0);

    // Simultaneous presses
    time_now = 24'h050505;
    press(1, 0, 0, 0);
    press(1, 1, 0, 0);
    check("mode_up_adv", {30'h0, field_sel}, 32'd2);
    press(0, 1, 1, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    wait_idle();
    check("simul_time_in", {8'h0, time_in}, {8'h0, EXP_SIM});

    // Out-of-range digits cleared on snapshot
    time_now = 24'h7A6B5C;
    mode_x(4);
    wait_idle();
    check("sanitize_time_in", {8'h0, time_in}, 32'h00000050);

    // Asynchronous reset during the load pulse
    time_now = 24'h010203;
    mode_x(4);
    check("pre_reset_set", {31'h0, set_time}, 32'd1);
    #2 reset_time_n = 1'b0;
    #1 check("async_reset", {4'h0, time_in, set_time, editing, field_sel}, 32'h0);
    tick();
    reset_time_n = 1'b1;
    tick();
    check("post_reset_time_in", {8'h0, time_in}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
